// File: rtl/savestate_pkg.sv
// savestate_pkg
// Shared types and constants for the savestate sequencer slice:
//   state_t       - sequencer FSM states
//   op_t          - engine operation direction (save / load)
//   TARGET_REWIND - engine target code used for the rewind buffer
//   INFO_*        - OSD info codes reported on completion
//   user_info()   - info code for a user slot operation
package savestate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        START,
        BUSY,
        RELEASE
    } state_t;

    typedef enum logic {
        SAVE,
        LOAD
    } op_t;

    localparam logic [2:0] TARGET_REWIND  = 3'd4;

    localparam logic [7:0] INFO_SAVE_BASE = 8'd6;
    localparam logic [7:0] INFO_REWIND    = 8'd14;
    localparam logic [7:0] INFO_ERR       = 8'd15;
    localparam logic [7:0] INFO_TIMEOUT   = 8'd16;

    // Save codes are even (6,8,10,12) and loads are the odd code just above.
    function automatic logic [7:0] user_info(input op_t op, input logic [1:0] slot);
        return INFO_SAVE_BASE + {5'd0, slot, 1'b0} + {7'd0, (op == LOAD)};
    endfunction

endpackage

// File: rtl/savestate_req_latch.sv
// savestate_req_latch
// One pending-request latch: remembers a requested operation and its target
// until the sequencer grants it.
// Parameters:
//   DROP_WHEN_PENDING - 0: a new request overwrites a pending one (UI rules)
//                       1: a request arriving while blocked or already
//                          pending is discarded and reported on drop
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   flush             - clear the pending request (savestates disallowed)
//   grant             - sequencer took the pending request
//   block             - sequencer busy (only used when DROP_WHEN_PENDING=1)
//   req_save/req_load - request pulses; load wins when both are set
//   target_in         - target captured with the request
//   pending/op/target - latched request
//   drop              - one-cycle pulse, a request was discarded
module savestate_req_latch
    import savestate_pkg::*;
#(
    parameter bit DROP_WHEN_PENDING = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       grant,
    input  logic       block,
    input  logic       req_save,
    input  logic       req_load,
    input  logic [2:0] target_in,
    output logic       pending,
    output op_t        op,
    output logic [2:0] target,
    output logic       drop
);

    logic req_any;
    logic discard;

    assign req_any = req_save | req_load;
    assign discard = DROP_WHEN_PENDING & req_any & (block | pending);

    // Flush beats everything; a fresh request beats a same-cycle grant so a
    // pulse arriving as the old request is taken is kept for later.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            op      <= SAVE;
            target  <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= discard;
            if (flush) begin
                pending <= 1'b0;
            end else if (req_any && !discard) begin
                pending <= 1'b1;
                op      <= req_load ? LOAD : SAVE;
                target  <= target_in;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/savestate_sequencer.sv
// savestate_sequencer
// Arbitrates user slot save/load and rewind capture/restore requests, pauses
// the core, issues one engine command, waits for completion, unpauses and
// reports an info code.
// Optional feature macro: SS_SEQ_TIMEOUT_EN enables a watchdog over PAUSE and
// BUSY; on expiry in BUSY the engine gets ss_abort and info 16 is reported.
// Parameters:
//   TIMEOUT_BITS - watchdog width; expiry when the MSB sets
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   allow_ss                  - savestates permitted (gates grants, flushes)
//   ui_save/ui_load, ui_slot  - user requests and slot
//   rw_capture/rw_restore     - rewind requests
//   core_paused               - core pause acknowledge
//   engine_done, engine_err   - engine completion and error flag
//   pause_req                 - core pause request
//   ss_start, ss_abort        - one-cycle engine start / abort
//   ss_load_mode, ss_target   - active operation, stable START..RELEASE
//   busy                      - sequencer not idle
//   rw_drop                   - rewind request discarded
//   info_req, info            - completion info strobe and held code
module savestate_sequencer
    import savestate_pkg::*;
#(
    parameter int TIMEOUT_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       allow_ss,
    input  logic       ui_save,
    input  logic       ui_load,
    input  logic [1:0] ui_slot,
    input  logic       rw_capture,
    input  logic       rw_restore,
    input  logic       core_paused,
    input  logic       engine_done,
    input  logic       engine_err,
    output logic       pause_req,
    output logic       ss_start,
    output logic       ss_load_mode,
    output logic [2:0] ss_target,
    output logic       ss_abort,
    output logic       busy,
    output logic       rw_drop,
    output logic       info_req,
    output logic [7:0] info
);

    state_t     state, state_next;
    logic       ui_pending, rw_pending;
    op_t        ui_op, rw_op;
    logic [2:0] ui_target, rw_target;
    logic       unused_ui_drop;
    logic       grant_ui, grant_rw;
    logic       op_done, latch_err, set_timeout, timeout_hit;
    op_t        act_op;
    logic [2:0] act_target;
    logic       act_rewind, act_err, act_timeout;
    logic [7:0] info_code;
    logic       info_valid;

    assign busy         = (state != IDLE);
    assign ss_load_mode = (act_op == LOAD);
    assign ss_target    = act_target;

    savestate_req_latch #(.DROP_WHEN_PENDING(1'b0)) u_ui_latch (
        .clk       (clk),
        .reset     (reset),
        .flush     (!allow_ss),
        .grant     (grant_ui),
        .block     (busy),
        .req_save  (ui_save),
        .req_load  (ui_load),
        .target_in ({1'b0, ui_slot}),
        .pending   (ui_pending),
        .op        (ui_op),
        .target    (ui_target),
        .drop      (unused_ui_drop)
    );

    savestate_req_latch #(.DROP_WHEN_PENDING(1'b1)) u_rw_latch (
        .clk       (clk),
        .reset     (reset),
        .flush     (!allow_ss),
        .grant     (grant_rw),
        .block     (busy),
        .req_save  (rw_capture),
        .req_load  (rw_restore),
        .target_in (TARGET_REWIND),
        .pending   (rw_pending),
        .op        (rw_op),
        .target    (rw_target),
        .drop      (rw_drop)
    );

`ifdef SS_SEQ_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wd_count;

    // Restarts on every state change so PAUSE and BUSY each get a full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_count <= '0;
        end else if (state_next != state) begin
            wd_count <= '0;
        end else if (state == PAUSE || state == BUSY) begin
            wd_count <= wd_count + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_hit = wd_count[TIMEOUT_BITS-1];
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_BITS;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The core stays paused from PAUSE through BUSY; UI wins arbitration.
    // A completing engine_done takes precedence over a same-cycle timeout.
    always_comb begin
        state_next  = state;
        grant_ui    = 1'b0;
        grant_rw    = 1'b0;
        pause_req   = 1'b0;
        ss_start    = 1'b0;
        ss_abort    = 1'b0;
        op_done     = 1'b0;
        latch_err   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (allow_ss && ui_pending) begin
                    grant_ui   = 1'b1;
                    state_next = PAUSE;
                end else if (allow_ss && rw_pending) begin
                    grant_rw   = 1'b1;
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                pause_req = 1'b1;
                if (timeout_hit) begin
                    set_timeout = 1'b1;
                    state_next  = RELEASE;
                end else if (core_paused) begin
                    state_next = START;
                end
            end
            START: begin
                pause_req  = 1'b1;
                ss_start   = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                pause_req = 1'b1;
                if (engine_done) begin
                    latch_err  = 1'b1;
                    state_next = RELEASE;
                end else if (timeout_hit) begin
                    ss_abort    = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (!core_paused) begin
                    op_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Timeout outranks error, error outranks the op's own code; a clean
    // rewind capture reports nothing.
    always_comb begin
        info_code  = user_info(act_op, act_target[1:0]);
        info_valid = 1'b1;
        if (act_timeout) begin
            info_code = INFO_TIMEOUT;
        end else if (act_err) begin
            info_code = INFO_ERR;
        end else if (act_rewind) begin
            info_code  = INFO_REWIND;
            info_valid = (act_op == LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_op      <= SAVE;
            act_target  <= '0;
            act_rewind  <= 1'b0;
            act_err     <= 1'b0;
            act_timeout <= 1'b0;
            info_req    <= 1'b0;
            info        <= '0;
        end else begin
            info_req <= op_done & info_valid;
            if (op_done && info_valid) begin
                info <= info_code;
            end
            if (grant_ui || grant_rw) begin
                act_op      <= grant_ui ? ui_op : rw_op;
                act_target  <= grant_ui ? ui_target : rw_target;
                act_rewind  <= grant_rw;
                act_err     <= 1'b0;
                act_timeout <= 1'b0;
            end
            if (latch_err) begin
                act_err <= engine_err;
            end
            if (set_timeout) begin
                act_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_savestate_sequencer.sv
// tb_savestate_sequencer
// Directed bench for savestate_sequencer. A transaction-level model holds the
// engine operations and info codes each scenario must produce; one compare
// process matches every ss_start / info_req / rw_drop / ss_abort against it
// and checks the held outputs every cycle. Core and engine are small
// responders: the core acknowledges pause three cycles late, the engine
// answers ss_start after a fixed delay.
// Optional feature macro: SS_SEQ_TIMEOUT_EN adds the watchdog scenario.
module tb_savestate_sequencer;

    localparam int TB_TIMEOUT_BITS = 4;
`ifdef SS_SEQ_TIMEOUT_EN
    localparam int DONE_DELAY = 5;
`else
    localparam int DONE_DELAY = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       allow_ss, ui_save, ui_load, rw_capture, rw_restore;
    logic [1:0] ui_slot;
    logic       core_paused, engine_done, engine_err;
    logic       pause_req, ss_start, ss_load_mode, ss_abort, busy, rw_drop, info_req;
    logic [2:0] ss_target;
    logic [7:0] info;

    int tests = 0;
    int failures = 0;

    bit exp_load[$];
    int exp_target[$];
    int exp_info[$];
    int exp_drops = 0;
    int exp_aborts = 0;
    int model_info = 0;
    int start_count = 0;
    int cycle = 0;
    int last_start_cycle = 0;
    int abort_cycle = -1;
    bit in_op = 1'b0;
    bit op_load = 1'b0;
    int op_target = 0;
    bit pause_seen = 1'b0;

    bit       force_paused = 1'b0;
    logic [2:0] pr_hist = 3'b000;
    bit       withhold_done = 1'b0;
    bit       err_flag = 1'b0;
    int       eng_count = 0;

    savestate_sequencer #(.TIMEOUT_BITS(TB_TIMEOUT_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .allow_ss     (allow_ss),
        .ui_save      (ui_save),
        .ui_load      (ui_load),
        .ui_slot      (ui_slot),
        .rw_capture   (rw_capture),
        .rw_restore   (rw_restore),
        .core_paused  (core_paused),
        .engine_done  (engine_done),
        .engine_err   (engine_err),
        .pause_req    (pause_req),
        .ss_start     (ss_start),
        .ss_load_mode (ss_load_mode),
        .ss_target    (ss_target),
        .ss_abort     (ss_abort),
        .busy         (busy),
        .rw_drop      (rw_drop),
        .info_req     (info_req),
        .info         (info)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Info code the specification assigns to a finished operation; -1 = none.
    function automatic int spec_info(input bit is_rewind, input bit load, input int slot,
                                     input bit err, input bit tmo);
        if (tmo) return 16;
        if (err) return 15;
        if (is_rewind) return load ? 14 : -1;
        return load ? (7 + 2 * slot) : (6 + 2 * slot);
    endfunction

    task automatic expect_op(input bit is_rewind, input bit load, input int slot,
                             input bit err, input bit tmo);
        int code;
        code = spec_info(is_rewind, load, slot, err, tmo);
        exp_load.push_back(load);
        exp_target.push_back(is_rewind ? 4 : slot);
        if (code >= 0) exp_info.push_back(code);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle request pulse; called just after a negedge.
    task automatic applyStimulus(input bit s_save, input bit s_load, input bit s_cap,
                                 input bit s_rest, input logic [1:0] slot);
        ui_save    = s_save;
        ui_load    = s_load;
        rw_capture = s_cap;
        rw_restore = s_rest;
        ui_slot    = slot;
        @(negedge clk);
        ui_save    = 1'b0;
        ui_load    = 1'b0;
        rw_capture = 1'b0;
        rw_restore = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        checkOutput({name, "_idle"}, int'(quiet >= 4), 1);
    endtask

    task automatic wait_start(input string name, input int budget);
        int s0;
        int n;
        s0 = start_count;
        n = 0;
        while (start_count == s0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_started"}, int'(start_count != s0), 1);
    endtask

    task automatic check_drained(input string name);
        checkOutput({name, "_ops_left"}, exp_load.size(), 0);
        checkOutput({name, "_info_left"}, exp_info.size(), 0);
        checkOutput({name, "_drops_left"}, exp_drops, 0);
        checkOutput({name, "_aborts_left"}, exp_aborts, 0);
    endtask

    task automatic check_all_zero(input string name);
        checkOutput({name, "_pause_req"}, pause_req, 0);
        checkOutput({name, "_ss_start"}, ss_start, 0);
        checkOutput({name, "_load_mode"}, ss_load_mode, 0);
        checkOutput({name, "_target"}, ss_target, 0);
        checkOutput({name, "_abort"}, ss_abort, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_rw_drop"}, rw_drop, 0);
        checkOutput({name, "_info_req"}, info_req, 0);
        checkOutput({name, "_info"}, info, 0);
    endtask

    // Core acknowledges pause (and un-pause) three cycles late, unless forced.
    initial begin
        core_paused = 1'b0;
        forever begin
            @(negedge clk);
            pr_hist     = {pr_hist[1:0], pause_req};
            core_paused = force_paused | pr_hist[2];
        end
    end

    // Engine answers each ss_start with a done pulse after DONE_DELAY cycles.
    initial begin
        engine_done = 1'b0;
        engine_err  = 1'b0;
        forever begin
            @(negedge clk);
            engine_done = 1'b0;
            engine_err  = 1'b0;
            if (eng_count > 0) begin
                eng_count--;
                if (eng_count == 0) begin
                    engine_done = 1'b1;
                    engine_err  = err_flag;
                end
            end
            if (ss_start && !withhold_done) eng_count = DONE_DELAY;
        end
    end

    // Compare process: every event must be one the model expects.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (pause_req) pause_seen = 1'b1;
            if (reset) begin
                model_info = 0;
                in_op      = 1'b0;
            end
            if (ss_start) begin
                start_count++;
                last_start_cycle = cycle;
                checkOutput("start_expected", int'(exp_load.size() > 0), 1);
                checkOutput("start_with_pause_req", pause_req, 1);
                if (exp_load.size() > 0) begin
                    op_load   = exp_load.pop_front();
                    op_target = exp_target.pop_front();
                    in_op     = 1'b1;
                    checkOutput("start_load_mode", ss_load_mode, op_load);
                    checkOutput("start_target", ss_target, op_target);
                end
            end else if (in_op) begin
                if (busy) begin
                    checkOutput("hold_load_mode", ss_load_mode, op_load);
                    checkOutput("hold_target", ss_target, op_target);
                end else begin
                    in_op = 1'b0;
                end
            end
            if (info_req) begin
                checkOutput("info_expected", int'(exp_info.size() > 0), 1);
                if (exp_info.size() > 0) model_info = exp_info.pop_front();
            end
            checkOutput("info_value", info, model_info);
            if (rw_drop) begin
                checkOutput("drop_expected", int'(exp_drops > 0), 1);
                if (exp_drops > 0) exp_drops--;
            end
            if (ss_abort) begin
                abort_cycle = cycle;
                checkOutput("abort_expected", int'(exp_aborts > 0), 1);
                if (exp_aborts > 0) exp_aborts--;
            end
            if (pause_req) checkOutput("pause_implies_busy", busy, 1);
        end
    end

    initial begin
        int s0;
        allow_ss   = 1'b1;
        ui_save    = 1'b0;
        ui_load    = 1'b0;
        ui_slot    = 2'd0;
        rw_capture = 1'b0;
        rw_restore = 1'b0;

        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // User save to slot 2.
        s0 = start_count;
        expect_op(1'b0, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_idle("save2", 200);
        checkOutput("save2_info", info, 10);
        checkOutput("save2_starts", start_count - s0, 1);
        check_drained("save2");

        // UI load slot 1 collides with rewind capture: UI first.
        s0 = start_count;
        expect_op(1'b0, 1'b1, 1, 1'b0, 1'b0);
        expect_op(1'b1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        wait_idle("collide", 300);
        checkOutput("collide_info", info, 9);
        checkOutput("collide_starts", start_count - s0, 2);
        check_drained("collide");

        // Rewind restore while busy is dropped; restore in idle reports 14.
        s0 = start_count;
        expect_op(1'b0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_start("drop", 50);
        exp_drops = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        wait_idle("drop", 200);
        checkOutput("drop_starts", start_count - s0, 1);
        checkOutput("drop_info", info, 6);
        expect_op(1'b1, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        wait_idle("restore", 200);
        checkOutput("restore_info", info, 14);
        check_drained("restore");

        // While a capture runs, a save is overwritten by a load of slot 3.
        s0 = start_count;
        expect_op(1'b1, 1'b0, 0, 1'b0, 1'b0);
        expect_op(1'b0, 1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_start("overwrite", 50);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        wait_idle("overwrite", 300);
        checkOutput("overwrite_info", info, 13);
        checkOutput("overwrite_starts", start_count - s0, 2);
        check_drained("overwrite");

        // Engine error on a save of slot 1.
        err_flag = 1'b1;
        expect_op(1'b0, 1'b0, 1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_idle("err", 200);
        err_flag = 1'b0;
        checkOutput("err_info", info, 15);
        check_drained("err");

        // Savestates disallowed: pending request flushed, never granted.
        s0 = start_count;
        pause_seen = 1'b0;
        allow_ss = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        tick(3);
        allow_ss = 1'b1;
        tick(8);
        checkOutput("flush_pause_seen", pause_seen, 0);
        checkOutput("flush_starts", start_count - s0, 0);
        checkOutput("flush_busy", busy, 0);

        // Grant latency with the core already paused.
        force_paused = 1'b1;
        tick(2);
        expect_op(1'b0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        checkOutput("lat_n1_pause_req", pause_req, 0);
        @(negedge clk);
        checkOutput("lat_n2_pause_req", pause_req, 1);
        checkOutput("lat_n2_ss_start", ss_start, 0);
        @(negedge clk);
        checkOutput("lat_n3_ss_start", ss_start, 1);
        @(negedge clk);
        force_paused = 1'b0;
        wait_idle("latency", 200);
        checkOutput("latency_info", info, 12);
        check_drained("latency");

        // Reset in BUSY aborts silently; a late engine_done in IDLE is ignored.
        expect_op(1'b0, 1'b0, 2, 1'b0, 1'b0);
        void'(exp_info.pop_back());
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_start("rst_busy", 50);
        tick(1);
        checkOutput("rst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_busy");
        reset = 1'b0;
        tick(12);
        wait_idle("rst_busy", 100);
        check_drained("rst_busy");

`ifdef SS_SEQ_TIMEOUT_EN
        // Engine never answers: abort after 8 BUSY cycles, info 16.
        withhold_done = 1'b1;
        exp_aborts = 1;
        expect_op(1'b0, 1'b1, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_start("timeout", 50);
        wait_idle("timeout", 200);
        withhold_done = 1'b0;
        checkOutput("timeout_abort_delay", abort_cycle - last_start_cycle, 9);
        checkOutput("timeout_info", info, 16);
        check_drained("timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
